// File: rtl/rv32_instr_decoder.sv
// Two-stage pipelined RV32 instruction decoder with valid/ready on both sides.
// Define RV32_DECODER_CUSTOM0_EN to decode custom-0 (opcode 0001011) as class 8.
module rv32_instr_decoder #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_class,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic [PC_W-1:0]  out_target,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef RV32_DECODER_CUSTOM0_EN
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;
    localparam logic [3:0] CL_CUSTOM0 = 4'd8;
`endif
    localparam logic [3:0] CL_R       = 4'd0;
    localparam logic [3:0] CL_I       = 4'd1;
    localparam logic [3:0] CL_LOAD    = 4'd2;
    localparam logic [3:0] CL_STORE   = 4'd3;
    localparam logic [3:0] CL_BRANCH  = 4'd4;
    localparam logic [3:0] CL_LUI     = 4'd5;
    localparam logic [3:0] CL_AUIPC   = 4'd6;
    localparam logic [3:0] CL_JAL     = 4'd7;
    localparam logic [3:0] CL_UNKNOWN = 4'd15;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        logic [3:0]      cls;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     imm;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } dec_t;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_instr_q, s1_instr_d;
    logic [PC_W-1:0]  s1_pc_q, s1_pc_d;
    logic             s2_valid_q, s2_valid_d;
    dec_t             s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             dec;
    logic             adv1, adv2;
    logic [2:0]       f3;
    logic [6:0]       f7;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = !rst && !flush && adv1;
    assign f3       = s1_instr_q[14:12];
    assign f7       = s1_instr_q[31:25];

    // Field extraction, immediate formation and legality for the word held in S1.
    always_comb begin
        dec        = '0;
        dec.opcode = s1_instr_q[6:0];
        dec.pc     = s1_pc_q;
        dec.rd     = s1_instr_q[11:7];
        dec.rs1    = s1_instr_q[19:15];
        dec.funct3 = f3;
        case (s1_instr_q[6:0])
            OP_R: begin
                dec.cls     = CL_R;
                dec.rs2     = s1_instr_q[24:20];
                dec.funct7  = f7;
                dec.illegal = !((f7 == 7'd0) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OP_I: begin
                dec.cls = CL_I;
                dec.imm = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
                if ((f3 == 3'b001) || (f3 == 3'b101)) dec.funct7 = f7;
                dec.illegal = ((f3 == 3'b001) && (f7 != 7'd0)) ||
                              ((f3 == 3'b101) && (f7 != 7'd0) && (f7 != F7_ALT));
            end
            OP_LOAD: begin
                dec.cls     = CL_LOAD;
                dec.imm     = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.cls     = CL_STORE;
                dec.rd      = 5'd0;
                dec.rs2     = s1_instr_q[24:20];
                dec.imm     = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
                dec.illegal = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                dec.cls     = CL_BRANCH;
                dec.rd      = 5'd0;
                dec.rs2     = s1_instr_q[24:20];
                dec.imm     = {{19{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[7],
                               s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
                dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LUI, OP_AUIPC: begin
                dec.cls    = (s1_instr_q[6:0] == OP_LUI) ? CL_LUI : CL_AUIPC;
                dec.rs1    = 5'd0;
                dec.funct3 = 3'd0;
                dec.imm    = {s1_instr_q[31:12], 12'd0};
            end
            OP_JAL: begin
                dec.cls    = CL_JAL;
                dec.rs1    = 5'd0;
                dec.funct3 = 3'd0;
                dec.imm    = {{11{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[19:12],
                              s1_instr_q[20], s1_instr_q[30:21], 1'b0};
            end
`ifdef RV32_DECODER_CUSTOM0_EN
            OP_CUSTOM0: begin
                dec.cls     = CL_CUSTOM0;
                dec.illegal = (f3 != 3'b000);
            end
`endif
            default: begin
                dec.cls     = CL_UNKNOWN;
                dec.illegal = 1'b1;
            end
        endcase
        // Target wraps modulo 2^PC_W; only control transfers carry one.
        if ((dec.cls == CL_BRANCH) || (dec.cls == CL_JAL))
            dec.target = s1_pc_q + PC_W'($signed(dec.imm));
    end

    // Pipeline advance, flush/reset squash and illegal counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_instr_d = s1_instr_q;
        s1_pc_d    = s1_pc_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        cnt_d      = cnt_q;
        if (in_valid && in_ready) begin
            s1_instr_d = in_instr;
            s1_pc_d    = in_pc;
        end
        if (adv1) s1_valid_d = in_valid && in_ready;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_d = dec;
        end
        if (s2_valid_q && out_ready && s2_q.illegal && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
        if (rst) begin
            s1_valid_d = 1'b0;
            s1_instr_d = '0;
            s1_pc_d    = '0;
            s2_valid_d = 1'b0;
            s2_d       = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        s1_valid_q <= s1_valid_d;
        s1_instr_q <= s1_instr_d;
        s1_pc_q    <= s1_pc_d;
        s2_valid_q <= s2_valid_d;
        s2_q       <= s2_d;
        cnt_q      <= cnt_d;
    end

    assign out_valid   = s2_valid_q;
    assign out_class   = s2_q.cls;
    assign out_opcode  = s2_q.opcode;
    assign out_rd      = s2_q.rd;
    assign out_rs1     = s2_q.rs1;
    assign out_rs2     = s2_q.rs2;
    assign out_funct3  = s2_q.funct3;
    assign out_funct7  = s2_q.funct7;
    assign out_imm     = s2_q.imm;
    assign out_target  = s2_q.target;
    assign out_pc      = s2_q.pc;
    assign out_illegal = s2_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
